msg_framer: RTL and testbench

Upstream stage of the sequence parser. Accepts per-message commands (stream ID, total byte length) plus a 32-bit payload word stream, and emits framed 32-bit words in the parser's input format: header word (little-endian length and stream), little-endian sequence word, then payload, with `last` on the final word. Keeps a per-stream 32-bit sequence counter so that every stream's frames are numbered consecutively from 0.

---
 rtl/framer_pkg.sv | 25 ++
 rtl/framer_seq_table.sv | 28 ++
 rtl/msg_framer.sv | 109 ++++++++++
 tb/tb_msg_framer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/framer_pkg.sv
// Shared types and helpers for the message framer: FSM states, header size,
// little-endian byte-swap helpers and the payload word count.
package framer_pkg;

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, PAY} framer_state_t;

  localparam int HDR_BYTES = 8;
  localparam int PW_BITS   = 14;

  function automatic logic [15:0] le16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [31:0] le32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // ceil((len - HDR_BYTES) / 4); only called for lengths already known to be >= HDR_BYTES.
  function automatic logic [PW_BITS-1:0] payloadWords(input logic [15:0] len);
    logic [16:0] body;
    body = {1'b0, len} - 17'(HDR_BYTES) + 17'd3;
    return PW_BITS'(body >> 2);
  endfunction

endpackage

// File: rtl/framer_seq_table.sv
// Per-stream 32-bit frame sequence counters with a combinational read port
// and a single increment strobe acting on the addressed entry.
module framer_seq_table #(
  parameter int NUM_STREAMS = 16,
  parameter int IDX_W       = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [IDX_W-1:0] rdIdx,
  input  logic             inc,
  output logic [31:0]      rdSeq
);

  logic [31:0] seqMem [NUM_STREAMS];

  // NOTE: this array must clear on reset (every stream restarts at sequence 0),
  // so it is built from flops rather than left to infer as an unreset RAM.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NUM_STREAMS; i++) seqMem[i] <= '0;
    end else if (inc) begin
      seqMem[rdIdx] <= seqMem[rdIdx] + 32'd1;
    end
  end

  assign rdSeq = seqMem[rdIdx];

endmodule

// File: rtl/msg_framer.sv
// Frames commanded messages for the sequence parser: header word, sequence
// word, then the payload stream passed straight through, last word flagged.
module msg_framer
  import framer_pkg::*;
#(
  parameter int NUM_STREAMS = 16,
  parameter int MAX_LEN     = 1024
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [15:0] cmd_stream,
  input  logic [15:0] cmd_len,
  input  logic        cmd_val,
  output logic        cmd_ready,
  input  logic [31:0] pay_data,
  input  logic        pay_val,
  output logic        pay_ready,
  output logic [31:0] out_data,
  output logic        out_val,
  input  logic        out_ready,
  output logic        out_last,
  output logic        cmd_err
);

  localparam int          IdxW        = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam logic [15:0] StreamLimit = 16'(NUM_STREAMS);
  localparam logic [15:0] LenMin      = 16'(HDR_BYTES);
  localparam logic [15:0] LenMax      = 16'(MAX_LEN);

  framer_state_t      state, stateNext;
  logic [15:0]        streamReg, lenReg;
  logic [PW_BITS-1:0] wordsLeft;
  logic [31:0]        seqCur;
  logic               cmdXfer, cmdBad, cmdAccept, cmdReject, payXfer, seqInc;

  // Gated by reset_b so the port reads 0 while reset is held, 1 as soon as it lifts.
  assign cmd_ready = (state == IDLE) && reset_b;
  assign cmdXfer   = cmd_val && (state == IDLE);
  assign cmdBad    = (cmd_len < LenMin) || (cmd_len > LenMax) || (cmd_stream >= StreamLimit);
  assign cmdAccept = cmdXfer && !cmdBad;
  assign cmdReject = cmdXfer && cmdBad;
  assign payXfer   = (state == PAY) && pay_val && out_ready;
  assign seqInc    = out_val && out_ready && out_last;

  framer_seq_table #(.NUM_STREAMS(NUM_STREAMS), .IDX_W(IdxW)) u_seq_table (
    .clk    (clk),
    .reset_b(reset_b),
    .rdIdx  (streamReg[IdxW-1:0]),
    .inc    (seqInc),
    .rdSeq  (seqCur)
  );

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state     <= IDLE;
      streamReg <= '0;
      lenReg    <= '0;
      wordsLeft <= '0;
      cmd_err   <= 1'b0;
    end else begin
      state   <= stateNext;
      cmd_err <= cmdReject;
      if (cmdAccept) begin
        streamReg <= cmd_stream;
        lenReg    <= cmd_len;
        wordsLeft <= payloadWords(cmd_len);
      end else if (payXfer) begin
        wordsLeft <= wordsLeft - PW_BITS'(1);
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    stateNext = state;
    out_val   = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    pay_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmdAccept) stateNext = HDR0;
      end
      HDR0: begin
        out_val  = 1'b1;
        out_data = {le16(lenReg), le16(streamReg)};
        if (out_ready) stateNext = HDR1;
      end
      HDR1: begin
        out_val  = 1'b1;
        out_data = le32(seqCur);
        out_last = (wordsLeft == '0);
        if (out_ready) stateNext = out_last ? IDLE : PAY;
      end
      PAY: begin
        out_val   = pay_val;
        pay_ready = out_ready;
        out_data  = pay_data;
        out_last  = (wordsLeft == PW_BITS'(1));
        if (pay_val && out_ready && out_last) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_msg_framer.sv
// Self-checking bench for msg_framer: directed cases plus random traffic,
// scored against a byte-level frame model with per-stream sequence numbers.
module tb_msg_framer;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        isPay;
    int          idx;
  } exp_t;

  typedef struct {
    logic [15:0] stream;
    logic [15:0] len;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset_b;
  logic [15:0] cmd_stream, cmd_len;
  logic        cmd_val, cmd_ready;
  logic [31:0] pay_data;
  logic        pay_val, pay_ready;
  logic [31:0] out_data;
  logic        out_val, out_ready, out_last, cmd_err;

  msg_framer #(.NUM_STREAMS(16), .MAX_LEN(1024)) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .cmd_stream(cmd_stream),
    .cmd_len   (cmd_len),
    .cmd_val   (cmd_val),
    .cmd_ready (cmd_ready),
    .pay_data  (pay_data),
    .pay_val   (pay_val),
    .pay_ready (pay_ready),
    .out_data  (out_data),
    .out_val   (out_val),
    .out_ready (out_ready),
    .out_last  (out_last),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] seqModel [16];
  cmd_t        cmdQ[$];
  logic [31:0] payQ[$], payRef[$];
  exp_t        expQ[$];
  logic [31:0] curFrame[$], lastFrame[$];
  bit          clrCmd, clrPay, errPending, hdrPending, prevStall;
  logic [31:0] prevData;
  logic        prevLast;
  bit          randReady, payGaps, stallEnable, stalled1, stalled3;
  int          stallCnt, errSeen;

  function automatic bit legal(input cmd_t c);
    return (c.len >= 16'd8) && (c.len <= 16'd1024) && (c.stream < 16'd16);
  endfunction

  function automatic int numPayWords(input logic [15:0] len);
    return (int'(len) - 8 + 3) / 4;
  endfunction

  // Wire order is little-endian: byte 0 of the value lands in the top byte lane.
  function automatic logic [31:0] swapBytes(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*(3-b) +: 8] = w[8*b +: 8];
    return r;
  endfunction

  task automatic enqueue(input logic [15:0] stream, input logic [15:0] len,
                         input bit directed, input logic [31:0] base);
    cmd_t c;
    logic [31:0] w;
    c.stream = stream;
    c.len    = len;
    cmdQ.push_back(c);
    if (legal(c)) begin
      for (int i = 0; i < numPayWords(len); i++) begin
        w = directed ? base + 32'(i) : $urandom;
        payQ.push_back(w);
        payRef.push_back(w);
      end
    end
  endtask

  task automatic onAccept(input cmd_t c);
    exp_t e;
    int n;
    n = numPayWords(c.len);
    e.isPay = 1'b0;
    e.data = swapBytes({c.stream, c.len}); e.last = 1'b0; e.idx = 0;
    expQ.push_back(e);
    e.data = swapBytes(seqModel[c.stream[3:0]]); e.last = (n == 0); e.idx = 1;
    expQ.push_back(e);
    seqModel[c.stream[3:0]] = seqModel[c.stream[3:0]] + 32'd1;
    e.isPay = 1'b1;
    for (int i = 0; i < n; i++) begin
      e.data = payRef.pop_front(); e.last = (i == n - 1); e.idx = i + 2;
      expQ.push_back(e);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    bit cmdX, payX, outX, frontPay;
    exp_t e;
    cmd_t c;
    if (clrCmd) begin cmd_val = 1'b0; clrCmd = 0; end
    if (clrPay) begin pay_val = 1'b0; clrPay = 0; end
    if (!cmd_val && cmdQ.size() > 0 && $urandom_range(0, 3) != 0) begin
      cmd_val = 1'b1; cmd_stream = cmdQ[0].stream; cmd_len = cmdQ[0].len;
    end
    if (!pay_val && payQ.size() > 0 && (!payGaps || $urandom_range(0, 2) != 0)) begin
      pay_val = 1'b1; pay_data = payQ[0];
    end
    if (stallCnt > 0) begin
      out_ready = 1'b0; stallCnt--;
    end else if (stallEnable && expQ.size() > 0 &&
                 ((expQ[0].idx == 1 && !stalled1) || (expQ[0].idx == 3 && !stalled3))) begin
      if (expQ[0].idx == 1) stalled1 = 1; else stalled3 = 1;
      out_ready = 1'b0; stallCnt = 6;
    end else begin
      out_ready = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    #1;
    cmdX = cmd_val && cmd_ready;
    payX = pay_val && pay_ready;
    outX = out_val && out_ready;
    frontPay = expQ.size() > 0 && expQ[0].isPay;
    check("cmd_ready", cmd_ready, expQ.size() == 0);
    check("pay_ready", pay_ready, frontPay ? out_ready : 1'b0);
    if (expQ.size() == 0) check("idle_out_val", out_val, 0);
    check("cmd_err", cmd_err, errPending);
    if (cmd_err) errSeen++;
    errPending = 0;
    if (hdrPending) check("word0_latency", out_val, 1);
    hdrPending = 0;
    if (prevStall) begin
      check("stall_val", out_val, 1);
      check("stall_data", out_data, prevData);
      check("stall_last", out_last, prevLast);
    end
    prevStall = out_val && !out_ready;
    prevData  = out_data;
    prevLast  = out_last;
    if (outX) begin
      if (expQ.size() == 0) begin
        check("unexpected_word", out_data, 32'hDEAD_0000);
      end else begin
        e = expQ.pop_front();
        check("out_data", out_data, e.data);
        check("out_last", out_last, e.last);
        curFrame.push_back(out_data);
        if (e.last) begin lastFrame = curFrame; curFrame.delete(); end
      end
    end
    if (payX) begin
      void'(payQ.pop_front());
      clrPay = 1;
    end
    if (cmdX) begin
      c = cmdQ.pop_front();
      clrCmd = 1;
      if (legal(c)) begin onAccept(c); hdrPending = 1; end
      else errPending = 1;
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((cmdQ.size() > 0 || expQ.size() > 0 || payQ.size() > 0 || cmd_val) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done"}, n < budget, 1);
    step();
    step();
  endtask

  task automatic doReset();
    reset_b = 1'b0;
    cmd_val = 1'b0; pay_val = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_out_val", out_val, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_pay_ready", pay_ready, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_cmd_err", cmd_err, 0);
    cmdQ.delete(); payQ.delete(); payRef.delete(); expQ.delete(); curFrame.delete();
    for (int s = 0; s < 16; s++) seqModel[s] = '0;
    clrCmd = 0; clrPay = 0; errPending = 0; hdrPending = 0; prevStall = 0; stallCnt = 0;
    @(negedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    #1;
    check("rel_cmd_ready", cmd_ready, 1);
    check("rel_out_val", out_val, 0);
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, errBase;
    logic [15:0] s, l;
    cmd_stream = '0; cmd_len = '0; cmd_val = 1'b0;
    pay_data = '0; pay_val = 1'b0; out_ready = 1'b0;
    randReady = 0; payGaps = 0; stallEnable = 0; errSeen = 0;
    @(negedge clk);
    doReset();

    // Basic frame
    enqueue(16'd12, 16'd20, 1, 32'hA1);
    drain("basic", 200);
    check("basic_len", lastFrame.size(), 5);
    check("basic_hdr", lastFrame[0], 32'h14000C00);
    check("basic_seq", lastFrame[1], 32'h0);
    check("basic_pay0", lastFrame[2], 32'hA1);
    check("basic_pay2", lastFrame[4], 32'hA3);

    // Same stream repeats, with a header-only frame on stream 14 in between
    enqueue(16'd12, 16'd21, 1, 32'h100);
    drain("rep1", 200);
    check("rep1_len", lastFrame.size(), 6);
    check("rep1_seq", lastFrame[1], 32'h01000000);
    enqueue(16'd14, 16'd8, 1, 32'h0);
    drain("hdronly", 200);
    check("hdronly_len", lastFrame.size(), 2);
    check("hdronly_hdr", lastFrame[0], 32'h08000E00);
    check("hdronly_seq", lastFrame[1], 32'h0);
    enqueue(16'd12, 16'd22, 1, 32'h200);
    drain("rep2", 200);
    check("rep2_seq", lastFrame[1], 32'h02000000);

    // Rejected commands
    errBase = errSeen;
    enqueue(16'd12, 16'd7, 1, 32'h0);
    enqueue(16'd12, 16'd1025, 1, 32'h0);
    enqueue(16'd16, 16'd20, 1, 32'h0);
    drain("reject", 200);
    check("reject_pulses", errSeen - errBase, 3);

    // Backpressure in HDR1 and mid-payload
    stallEnable = 1; stalled1 = 0; stalled3 = 0;
    enqueue(16'd3, 16'd40, 1, 32'hC0);
    drain("stall", 300);
    stallEnable = 0;
    check("stall_both_hit", stalled1 && stalled3, 1);
    check("stall_len", lastFrame.size(), 10);

    // Reset during the payload of stream 12, sequence 3
    enqueue(16'd12, 16'd40, 1, 32'hD0);
    n = 0;
    while (curFrame.size() < 3 && n < 200) begin step(); n++; end
    check("midrst_reached", n < 200, 1);
    check("midrst_seq", curFrame[1], 32'h03000000);
    doReset();
    enqueue(16'd12, 16'd12, 1, 32'hE0);
    drain("post_rst", 200);
    check("post_rst_seq", lastFrame[1], 32'h0);
    check("post_rst_len", lastFrame.size(), 3);

    // Largest legal message
    enqueue(16'd7, 16'd1024, 0, 32'h0);
    drain("maxlen", 2000);
    check("maxlen_len", lastFrame.size(), 256);

    // Random traffic
    randReady = 1; payGaps = 1;
    for (int i = 0; i < 200; i++) begin
      s = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(16, 20)) : 16'($urandom_range(0, 15));
      case ($urandom_range(0, 24))
        0:       l = 16'($urandom_range(0, 7));
        1:       l = 16'($urandom_range(1025, 1100));
        2:       l = 16'($urandom_range(1000, 1024));
        default: l = 16'($urandom_range(8, 80));
      endcase
      enqueue(s, l, 0, 32'h0);
    end
    drain("random", 60000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
